// File: rtl/lcd_text_buffer.sv
// Two-line x 16-column character frame buffer that streams full-screen refreshes to the lcd driver.
// Optional build macro LCD_TEXT_BLANK_ON_RESET_EN: buffer resets to spaces and starts dirty.
module lcd_text_buffer #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter logic [7:0]  LINE1_ADDR  = 8'h80,
    parameter logic [7:0]  LINE2_ADDR  = 8'hC0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       force_refresh,
    input  logic       lcd_busy,
    output logic [8:0] d_out,
    output logic       data_ready,
    output logic       refresh_busy
);

    localparam int unsigned CHARS    = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CHAR_W   = 8;
    localparam int unsigned WORD_W   = 9;
    localparam int unsigned SEQ_W    = 6;
    localparam int unsigned LINE_LEN = 16;
    localparam int unsigned L2_SEQ   = 17;
    localparam int unsigned LAST_SEQ = 33;
    localparam int unsigned CNT_W    = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SEQ_W-1:0]    seq;
    logic [SEQ_W-1:0]    seq_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                start_c;
    logic                dirty;
    logic [WORD_W-1:0]   word_c;
    logic [CHAR_W-1:0]   char_mem [CHARS];

`ifdef LCD_TEXT_BLANK_ON_RESET_EN
    localparam logic DIRTY_RST = 1'b1;

    // Character storage, blanked to spaces on reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CHARS; i++) begin
                char_mem[i] <= 8'h20;
            end
        end else if (wr_en) begin
            char_mem[wr_addr] <= wr_data;
        end
    end
`else
    localparam logic DIRTY_RST = 1'b0;

    // Character storage, contents undefined until written
    always_ff @(posedge clock) begin
        if (wr_en) begin
            char_mem[wr_addr] <= wr_data;
        end
    end
`endif

    // A write in the same cycle as a refresh start keeps the buffer dirty
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dirty <= DIRTY_RST;
        end else if (wr_en || force_refresh) begin
            dirty <= 1'b1;
        end else if (start_c) begin
            dirty <= 1'b0;
        end
    end

    // Next-state logic for the refresh sequencer
    always_comb begin
        state_nxt = state;
        seq_nxt   = seq;
        cnt_nxt   = cnt;
        start_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (dirty && !lcd_busy) begin
                    start_c   = 1'b1;
                    seq_nxt   = '0;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (lcd_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (cnt + CNT_W'(1) == CNT_W'(ACK_TIMEOUT)) begin
                    state_nxt = S_ISSUE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!lcd_busy) begin
                    if (seq == SEQ_W'(LAST_SEQ)) begin
                        state_nxt = S_IDLE;
                    end else begin
                        seq_nxt   = seq + SEQ_W'(1);
                        state_nxt = S_ISSUE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Word for the sequence slot about to be issued
    always_comb begin
        word_c = {1'b0, LINE1_ADDR};
        if (seq_nxt == SEQ_W'(0)) begin
            word_c = {1'b0, LINE1_ADDR};
        end else if (seq_nxt <= SEQ_W'(LINE_LEN)) begin
            word_c = {1'b1, char_mem[ADDR_W'(seq_nxt - SEQ_W'(1))]};
        end else if (seq_nxt == SEQ_W'(L2_SEQ)) begin
            word_c = {1'b0, LINE2_ADDR};
        end else begin
            word_c = {1'b1, char_mem[ADDR_W'(seq_nxt - SEQ_W'(2))]};
        end
    end

    // State and registered outputs; d_out is captured on entry to ISSUE and held until the next one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            seq          <= '0;
            cnt          <= '0;
            d_out        <= '0;
            data_ready   <= 1'b0;
            refresh_busy <= 1'b0;
        end else begin
            state        <= state_nxt;
            seq          <= seq_nxt;
            cnt          <= cnt_nxt;
            data_ready   <= (state_nxt == S_ISSUE);
            refresh_busy <= (state_nxt != S_IDLE);
            if (state_nxt == S_ISSUE) begin
                d_out <= word_c;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Bench for lcd_text_buffer: a driver model acknowledges each data_ready and a queue of expected words is checked per pulse.
module tb_lcd_text_buffer;

    localparam int unsigned TB_TO = 8;

    logic       clock;
    logic       reset_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       force_refresh;
    logic       lcd_busy;
    logic [8:0] d_out;
    logic       data_ready;
    logic       refresh_busy;

    int         n_tests;
    int         n_fail;
    int         cyc;
    int         pulse_cnt;
    int         last_pulse;
    int         prev_pulse;
    int         ack_cnt;
    int         ignore_n;
    int         base;
    int         c0;
    bit         hold_busy;
    logic [8:0] exp_q [$];
    logic [7:0] shadow [32];

    lcd_text_buffer #(
        .ACK_TIMEOUT (TB_TO),
        .LINE1_ADDR  (8'h80),
        .LINE2_ADDR  (8'hC0)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .force_refresh (force_refresh),
        .lcd_busy      (lcd_busy),
        .d_out         (d_out),
        .data_ready    (data_ready),
        .refresh_busy  (refresh_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: step to the falling edge, then run the driver model
    task automatic tick();
        logic [8:0] e;
        @(negedge clock);
        cyc++;
        if (data_ready === 1'b1) begin
            pulse_cnt++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
            check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("d_out", 32'(d_out), 32'(e));
            end
            if (ignore_n > 0) ignore_n--;
            else              ack_cnt = 5;
        end else if (ack_cnt > 0) begin
            ack_cnt--;
        end
        lcd_busy = hold_busy || (ack_cnt != 0);
    endtask

    task automatic write(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_force();
        force_refresh = 1'b1;
        tick();
        force_refresh = 1'b0;
    endtask

    task automatic push_screen();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, shadow[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, shadow[i]});
    endtask

    task automatic wait_pulses(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (pulse_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(pulse_cnt), 32'(target));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || refresh_busy !== 1'b0 || ack_cnt != 0) && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(refresh_busy), 32'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; pulse_cnt = 0;
        last_pulse = 0; prev_pulse = 0; ack_cnt = 0; ignore_n = 0;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        force_refresh = 1'b0; hold_busy = 1'b1; lcd_busy = 1'b1;

        repeat (3) tick();
        check("rst_d_out", 32'(d_out), 32'h000);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_refresh_busy", 32'(refresh_busy), 32'd0);
        reset_n = 1'b1;

        // Driver still initialising: nothing may be sent while lcd_busy is held
`ifdef LCD_TEXT_BLANK_ON_RESET_EN
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
`else
        for (int i = 0; i < 32; i++) begin
            shadow[i] = 8'(8'h30 + i);
            write(5'(i), shadow[i]);
        end
`endif
        push_screen();
        repeat (100) tick();
        check("hold_no_pulse", 32'(pulse_cnt), 32'd0);
        check("hold_refresh_busy", 32'(refresh_busy), 32'd0);
        hold_busy = 1'b0;
        wait_done("init");
        check("init_pulses", 32'(pulse_cnt), 32'd34);

        // Two characters on different lines
        hold_busy = 1'b1; lcd_busy = 1'b1;
        write(5'd5, 8'h41);  shadow[5]  = 8'h41;
        write(5'd20, 8'h42); shadow[20] = 8'h42;
        push_screen();
        tick();
        hold_busy = 1'b0;
        wait_done("ab");

        // Forced refresh of a clean buffer: first pulse two cycles after the request
        repeat (10) tick();
        base = pulse_cnt;
        c0 = cyc;
        push_screen();
        pulse_force();
        tick();
        check("force_pulse", 32'(pulse_cnt), 32'(base + 1));
        check("force_latency", 32'(last_pulse - c0), 32'd2);
        check("force_first_word", 32'(d_out), 32'h080);
        check("force_refresh_busy", 32'(refresh_busy), 32'd1);

        // Write to index 0 at seq 10: current screen unaffected, second screen follows
        wait_pulses("reach_seq10", base + 11, 1000);
        write(5'd0, 8'h5A);
        shadow[0] = 8'h5A;
        push_screen();
        wait_done("midwrite");
        check("midwrite_pulses", 32'(pulse_cnt), 32'(base + 68));

        // Unacknowledged word is re-sent unchanged after the timeout
        base = pulse_cnt;
        ignore_n = 1;
        exp_q.push_back({1'b0, 8'h80});
        push_screen();
        pulse_force();
        wait_pulses("retry_reach", base + 2, 200);
        check("retry_gap", 32'(last_pulse - prev_pulse), 32'(TB_TO + 1));
        wait_done("retry");

        // Reset in the middle of a refresh
        base = pulse_cnt;
        push_screen();
        pulse_force();
        wait_pulses("reach_seq20", base + 21, 1000);
        reset_n = 1'b0;
        #1;
        check("midrst_data_ready", 32'(data_ready), 32'd0);
        check("midrst_refresh_busy", 32'(refresh_busy), 32'd0);
        check("midrst_d_out", 32'(d_out), 32'h000);
        exp_q.delete();
        ack_cnt = 0;
        lcd_busy = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
`ifdef LCD_TEXT_BLANK_ON_RESET_EN
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
        push_screen();
        wait_done("post_reset_blank");
`else
        base = pulse_cnt;
        repeat (150) tick();
        check("post_reset_quiet", 32'(pulse_cnt), 32'(base));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_text_buffer.md
# lcd_text_buffer

Two-line, 16-column character frame buffer that sits directly upstream of the `lcd` driver. It replaces the fixed ROM/controller pair as the source of `d_in`/`data_ready`. It holds 32 display characters written by game logic and streams a full screen refresh to the driver whenever the buffer changes. Each refresh is one line-1 DDRAM address command, 16 characters, one line-2 DDRAM address command and 16 characters, all paced by the driver's `busy_flag`.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 16: cycles to wait for `lcd_busy` to rise after a `data_ready` pulse before re-issuing the same word.
- `LINE1_ADDR`, default 8'h80: Set-DDRAM command for line 1, column 0.
- `LINE2_ADDR`, default 8'hC0: Set-DDRAM command for line 2, column 0.

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  buffer write strobe, one character per cycle.
- `wr_addr`  in  5  character index; 0–15 is line 1, 16–31 is line 2.
- `wr_data`  in  8  character code.
- `force_refresh`  in  1  single-cycle request to refresh even if the buffer is clean.
- `lcd_busy`  in  1  driver `busy_flag`.
- `d_out`  out  9  {rs, data[7:0]} to driver `d_in`.
- `data_ready`  out  1  single-cycle "word valid" pulse to the driver.
- `refresh_busy`  out  1  high from refresh start until the last word completes.

## Operation
- Storage is a 32×8 register array. A write lands at the clock edge when `wr_en`=1. Writes are always accepted, including mid-refresh.
- `dirty` is set by `wr_en` or `force_refresh`. It is cleared when a refresh starts. If a write and a refresh start occur in the same cycle, `dirty` stays set.
- Sequence index `seq` is 6 bits, 0..33:
  - 0 → rs=0, `LINE1_ADDR`
  - 1..16 → rs=1, `buf[seq-1]`
  - 17 → rs=0, `LINE2_ADDR`
  - 18..33 → rs=1, `buf[seq-2]`
- FSM states:
  - IDLE: if `dirty` and `lcd_busy`=0, clear `dirty`, set `seq`=0, set `refresh_busy`=1, go to ISSUE.
  - ISSUE: load `d_out` from the sequence table, pulse `data_ready`, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: if `lcd_busy`=1, go to WAIT_DONE. If the counter reaches `ACK_TIMEOUT`, go to ISSUE with the same `seq` (retry). Otherwise keep counting.
  - WAIT_DONE: on `lcd_busy`=0, if `seq`=33 go to IDLE and clear `refresh_busy`; otherwise increment `seq` and go to ISSUE.
- The character code is captured into `d_out` at ISSUE. A later write to that index affects the next refresh only, and that refresh follows automatically because `dirty` is set.
- `d_out` is held constant from ISSUE until the next ISSUE. This satisfies the driver, which samples `d_in` one or more cycles after `data_ready`.
- While the driver initialises after power-up, `lcd_busy` stays 1 and IDLE waits.

## Timing
- Reset values: `d_out`=9'h000, `data_ready`=0, `refresh_busy`=0, state=IDLE, `seq`=0, timeout counter=0. `dirty` and buffer reset values are set by Configuration.
- Latency: the first `data_ready` occurs 2 cycles after a clean-to-dirty write while `lcd_busy`=0 (write edge, then IDLE→ISSUE edge).
- `data_ready` is exactly 1 cycle wide and occurs once per ISSUE.
- After WAIT_DONE sees `lcd_busy`=0, the next `data_ready` follows 1 cycle later.
- A full refresh is 34 handshakes. With the driver's timing that is 2×2 ms + 32×~40 µs.
- When `reset_n` is asserted mid-refresh, outputs clear immediately and the partially written screen is left as is. After reset the block restarts only if `dirty`.
- Retry after timeout re-sends an identical `d_out`. There is no retry limit.

## Configuration
- `LCD_TEXT_BLANK_ON_RESET_EN` defined: the buffer resets asynchronously to 8'h20 (space) in all 32 entries. `dirty` resets to 1, so the first refresh after driver init blanks the display.
- Macro undefined: the buffer has no reset (contents undefined until written) and `dirty` resets to 0. No refresh occurs until a write or `force_refresh`.

## Test plan
- Reset with macro defined; hold `lcd_busy`=1 for 100 cycles, then 0; the bench model acknowledges each pulse with `lcd_busy`=1 for 5 cycles. Expect 34 `data_ready` pulses with `d_out` = 0x080, 16×0x120, 0x0C0, 16×0x120, then `refresh_busy`=0.
- Macro undefined: write 'A' (0x41) to index 5 and 'B' (0x42) to index 20. In the refresh, expect word 6 = 0x141 and word 22 = 0x142.
- During a refresh at `seq`=10, write index 0 = 0x5A. Expect the current refresh to complete, then a second refresh in which word 1 = 0x15A.
- The bench model ignores the first `data_ready`. Expect a repeat pulse with identical `d_out` after `ACK_TIMEOUT`+1 cycles, and the sequence then continues.
- Assert `reset_n`=0 at `seq`=20. Expect `data_ready`=0, `refresh_busy`=0 and `d_out`=0 immediately. After release, with the macro undefined and no writes, expect no pulses.
- With the buffer clean and `lcd_busy`=0, pulse `force_refresh`. Expect the first `data_ready` 2 cycles later with `d_out`=0x080.
